conway_gen_engine: RTL

- Next-generation compute stage on the selector port of the 4x16-bit cell memory (64 cells, 8x8 grid).
- On `start`, reads all four words, applies Conway's B3/S23 rule to every cell in one compute cycle, then writes all four words back.
- Drives the memory's selector-side address, write-enable and write-data inputs, and consumes its selector-side read data.
- The VGA read port is untouched; this block is the only writer of the selector port.

---
 rtl/conway_pkg.sv | 62 ++++++
 rtl/conway_cell_rule.sv | 21 ++
 rtl/conway_gen_engine.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/conway_pkg.sv
// Shared types, sizes and cell-mapping helpers for the Conway generation engine.
package conway_pkg;

    localparam int unsigned GRID_W     = 8;
    localparam int unsigned GRID_H     = 8;
    localparam int unsigned WORD_W     = 16;
    localparam int unsigned NUM_WORDS  = 4;
    localparam int unsigned ADDR_W     = 2;
    localparam int unsigned NUM_CELLS  = GRID_W * GRID_H;
    localparam int unsigned CELL_IDX_W = $clog2(NUM_CELLS);
    localparam int unsigned WORD_SH    = $clog2(WORD_W);
    localparam int unsigned NBR_W      = 8;
    localparam int unsigned NBR_CNT_W  = 4;
    localparam int unsigned ALIVE_W    = 7;
    localparam int unsigned GEN_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD      = 3'd1,
        ST_RD_TAIL = 3'd2,
        ST_COMP    = 3'd3,
        ST_WR      = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              wr_en;
        logic [WORD_W-1:0] wdata;
    } mem_req_t;

    function automatic int unsigned row_of(int unsigned word, int unsigned bit_i);
        return 2 * word + (bit_i >> 3);
    endfunction

    function automatic int unsigned col_of(int unsigned bit_i);
        return bit_i & 7;
    endfunction

    // Row-major index; equals word*16 + bit for this packing.
    function automatic int unsigned cell_idx(int unsigned row, int unsigned col);
        return row * GRID_W + col;
    endfunction

    function automatic int wrap(int v, int unsigned n);
        return (v + int'(n)) % int'(n);
    endfunction

    function automatic logic [CELL_IDX_W-1:0] word_base(logic [ADDR_W-1:0] w);
        return {w, {WORD_SH{1'b0}}};
    endfunction

    function automatic logic [ALIVE_W-1:0] popcount(logic [NUM_CELLS-1:0] v);
        logic [ALIVE_W-1:0] s;
        s = '0;
        for (int i = 0; i < int'(NUM_CELLS); i++) begin
            s = s + ALIVE_W'(v[i]);
        end
        return s;
    endfunction

endpackage

// File: rtl/conway_cell_rule.sv
// B3/S23 next-state for one cell from its own state and eight neighbours.
module conway_cell_rule
    import conway_pkg::*;
(
    input  logic             self_alive,
    input  logic [NBR_W-1:0] nbr,
    output logic             next_alive_c
);

    logic [NBR_CNT_W-1:0] n_cnt;

    always_comb begin
        n_cnt = '0;
        for (int i = 0; i < int'(NBR_W); i++) begin
            n_cnt = n_cnt + NBR_CNT_W'(nbr[i]);
        end
    end

    assign next_alive_c = (n_cnt == NBR_CNT_W'(3)) || (self_alive && (n_cnt == NBR_CNT_W'(2)));

endmodule

// File: rtl/conway_gen_engine.sv
// One Conway generation step over the 4x16-bit cell memory: read 4 words, compute, write 4 words.
// Build option: define CONWAY_TORUS_EN for toroidal neighbour wrap; otherwise the border is dead.
module conway_gen_engine
    import conway_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 mem_wr_en,
    output logic [WORD_W-1:0]    mem_wdata,
    input  logic [WORD_W-1:0]    mem_rdata,
    output logic [GEN_W-1:0]     gen_count,
    output logic [ALIVE_W-1:0]   alive_count
);

    if (RD_LAT != 1) begin : g_rd_lat_check
        $error("conway_gen_engine: only RD_LAT == 1 is supported");
    end

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    cnt_q, cnt_d;
    mem_req_t             req_d, req_q;
    logic                 busy_d, done_d;
    logic                 cap_valid_q;
    logic [ADDR_W-1:0]    cap_word_q;
    logic [NUM_CELLS-1:0] cur_q, next_q, next_c;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and word counter
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RD;
            end
            ST_RD: begin
                if (cnt_q == ADDR_W'(NUM_WORDS - 1)) state_d = ST_RD_TAIL;
                else                                 cnt_d   = cnt_q + ADDR_W'(1);
            end
            ST_RD_TAIL: state_d = ST_COMP;
            ST_COMP:    state_d = ST_WR;
            ST_WR: begin
                if (cnt_q == ADDR_W'(NUM_WORDS - 1)) state_d = ST_DONE;
                else                                 cnt_d   = cnt_q + ADDR_W'(1);
            end
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state; registered below
    always_comb begin
        req_d  = '0;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            ST_RD: begin
                req_d.addr = cnt_d;
                busy_d     = 1'b1;
            end
            ST_RD_TAIL, ST_COMP: begin
                busy_d = 1'b1;
            end
            ST_WR: begin
                req_d.addr  = cnt_d;
                req_d.wr_en = 1'b1;
                // First write leaves COMP before next_q is loaded, so take the rule outputs directly.
                req_d.wdata = (state_q == ST_COMP) ? next_c[WORD_W-1:0]
                                                   : next_q[word_base(cnt_d) +: WORD_W];
                busy_d      = 1'b1;
            end
            ST_DONE: begin
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            req_q <= req_d;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

    assign mem_addr  = req_q.addr;
    assign mem_wr_en = req_q.wr_en;
    assign mem_wdata = req_q.wdata;

    // Read capture lags the address by one cycle; generation result and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_valid_q <= 1'b0;
            cap_word_q  <= '0;
            cur_q       <= '0;
            next_q      <= '0;
            alive_count <= '0;
            gen_count   <= '0;
        end else begin
            cap_valid_q <= (state_q == ST_RD);
            cap_word_q  <= cnt_q;
            if (cap_valid_q) begin
                cur_q[word_base(cap_word_q) +: WORD_W] <= mem_rdata;
            end
            if (state_q == ST_COMP) begin
                next_q      <= next_c;
                alive_count <= popcount(next_c);
            end
            if (state_d == ST_DONE) begin
                gen_count <= gen_count + GEN_W'(1);
            end
        end
    end

    // Neighbourhood wiring: k walks the 3x3 window, centre (k == 4) excluded
    for (genvar i = 0; i < int'(NUM_CELLS); i++) begin : g_cell
        localparam int R = int'(row_of(i / WORD_W, i % WORD_W));
        localparam int C = int'(col_of(i % WORD_W));
        logic [NBR_W-1:0] nbr;

        for (genvar k = 0; k < 9; k++) begin : g_nbr
            if (k != 4) begin : g_used
                localparam int NR = R + k / 3 - 1;
                localparam int NC = C + k % 3 - 1;
                localparam int NI = (k < 4) ? k : k - 1;
`ifdef CONWAY_TORUS_EN
                assign nbr[NI] = cur_q[CELL_IDX_W'(cell_idx(wrap(NR, GRID_H), wrap(NC, GRID_W)))];
`else
                if (NR < 0 || NR >= int'(GRID_H) || NC < 0 || NC >= int'(GRID_W)) begin : g_edge
                    assign nbr[NI] = 1'b0;
                end else begin : g_in
                    assign nbr[NI] = cur_q[CELL_IDX_W'(cell_idx(NR, NC))];
                end
`endif
            end
        end

        conway_cell_rule u_rule (
            .self_alive   (cur_q[i]),
            .nbr          (nbr),
            .next_alive_c (next_c[i])
        );
    end

endmodule
